gpio_controller_debounce: RTL and testbench

- Per-pin glitch/debounce filter on the synchronized GPIO input bus.
- Sits between the 2-flop input synchronizer and the edge-interrupt detector / input_data CSR capture. It consumes the synced bus and produces a filtered bus in its place.
- One shared prescaler generates a sample tick. Each pin changes its output only after the new level is seen on a programmable number of consecutive ticks. Per-pin bypass is supported.

---
 rtl/gpio_controller_debounce_if.sv | 31 +++
 rtl/gpio_controller_debounce.sv | 61 ++++++
 tb/tb_gpio_controller_debounce.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_controller_debounce_if.sv
// rtl/gpio_controller_debounce_if.sv - GPIO debounce filter bus: synced inputs, CSR config, filtered outputs
interface gpio_controller_debounce_if #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 4,
  parameter int PRE_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] filter_enable;
  logic [PRE_W-1:0] prescale;
  logic [CNT_W-1:0] threshold;
  logic [WIDTH-1:0] out_data;
  logic             sample_tick;

  modport master (
    output in_data,
    output filter_enable,
    output prescale,
    output threshold,
    input  out_data,
    input  sample_tick
  );

  modport slave (
    input  in_data,
    input  filter_enable,
    input  prescale,
    input  threshold,
    output out_data,
    output sample_tick
  );
endinterface

// File: rtl/gpio_controller_debounce.sv
// rtl/gpio_controller_debounce.sv - per-pin GPIO glitch/debounce filter with shared sample prescaler
module gpio_controller_debounce #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 4,
  parameter int PRE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gpio_controller_debounce_if.slave bus
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Tick is gated by reset so it reads 0 while rst_n is low, even with prescale = 0.
  // The >= compare means lowering prescale below pre_cnt ticks at once instead of wrapping.
  assign tick            = rst_n && (pre_cnt >= bus.prescale);
  assign bus.sample_tick = tick;
  assign bus.out_data    = out_q;

  // Shared prescaler: free-running count that restarts on every tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Per-pin filter: bypassed pins follow input each clk; filtered pins commit after
  // threshold+1 consecutive differing ticks, any matching tick restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!bus.filter_enable[i]) begin
          out_q[i] <= bus.in_data[i];
          cnt[i]   <= '0;
        end else if (tick) begin
          if (bus.in_data[i] == out_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] >= bus.threshold) begin
            out_q[i] <= bus.in_data[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_controller_debounce.sv
// tb/tb_gpio_controller_debounce.sv - scoreboard bench for gpio_controller_debounce
module tb_gpio_controller_debounce;

  localparam int WIDTH = 256;
  localparam int CNT_W = 4;
  localparam int PRE_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_controller_debounce_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

  gpio_controller_debounce #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // kind: 0 = single out_data bit, 1 = sample_tick, 2 = whole out_data bus
  typedef struct {
    int               at;
    int               kind;
    int               idx;
    logic [WIDTH-1:0] val;
    string            name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push_exp(input int k, input int kind, input int idx,
                          input logic [WIDTH-1:0] val, input string name);
    exp_t e;
    int   pos;
    e.at = cyc + k; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    pos = q.size();
    for (int j = 0; j < q.size(); j++) begin
      if (q[j].at > e.at) begin
        pos = j;
        break;
      end
    end
    q.insert(pos, e);
  endtask

  task automatic exp_bit(input int k, input int idx, input logic v, input string name);
    logic [WIDTH-1:0] w;
    w = '0;
    w[0] = v;
    push_exp(k, 0, idx, w, name);
  endtask

  task automatic exp_tick(input int k, input logic v, input string name);
    logic [WIDTH-1:0] w;
    w = '0;
    w[0] = v;
    push_exp(k, 1, 0, w, name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: at each negedge pop every expectation due this cycle and compare.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      logic [WIDTH-1:0] act;
      e = q.pop_front();
      n_checks++;
      case (e.kind)
        0:       begin act = '0; act[0] = bus.out_data[e.idx]; end
        1:       begin act = '0; act[0] = bus.sample_tick; end
        default: act = bus.out_data;
      endcase
      if (e.at != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.at, cyc);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s at cycle %0d: got %h, expected %h", e.name, cyc, act, e.val);
      end
    end
  end

  initial begin
    int r;
    int to;
    logic [WIDTH-1:0] w;

    bus.in_data       = '0;
    bus.filter_enable = '1;
    bus.prescale      = '0;
    bus.threshold     = '0;
    rst_n             = 1'b0;
    step(3);

    // reset state
    push_exp(0, 2, 0, '0, "reset_out");
    exp_tick(0, 1'b0, "reset_tick");
    step(1);
    rst_n = 1'b1;

    // bypass: pin 5 toggles every cycle, output follows one cycle later
    bus.filter_enable = '0;
    for (int i = 0; i < 6; i++) begin
      bus.in_data[5] = ~i[0];
      exp_bit(1, 5, ~i[0], "bypass_follow");
      step(1);
    end
    bus.in_data = '0;
    step(2);
    bus.filter_enable = '1;

    // basic filter: prescale 0, threshold 2, commit on third tick
    bus.prescale  = 16'd0;
    bus.threshold = 4'd2;
    step(1);
    bus.in_data[0] = 1'b1;
    exp_bit(2, 0, 1'b0, "basic_hold");
    exp_bit(3, 0, 1'b1, "basic_commit");
    exp_bit(6, 0, 1'b1, "basic_stay");
    step(6);

    // glitch rejection on pin 1, twice to show the count restarted
    for (int g = 0; g < 2; g++) begin
      bus.in_data[1] = 1'b1;
      exp_bit(1, 1, 1'b0, "glitch_a");
      exp_bit(3, 1, 1'b0, "glitch_b");
      exp_bit(5, 1, 1'b0, "glitch_c");
      step(2);
      bus.in_data[1] = 1'b0;
      step(1);
    end
    step(3);

    // prescaled: prescale 3, threshold 1, reset to align tick phase
    bus.prescale  = 16'd3;
    bus.threshold = 4'd1;
    bus.in_data   = '0;
    rst_n = 1'b0;
    r = cyc;
    exp_tick(1, 1'b0, "pre_tick_c1");
    exp_tick(2, 1'b0, "pre_tick_c2");
    exp_tick(3, 1'b0, "pre_tick_c3");
    exp_tick(4, 1'b1, "pre_tick_first");
    exp_tick(5, 1'b0, "pre_tick_after");
    exp_tick(8, 1'b1, "pre_tick_second");
    exp_tick(12, 1'b1, "pre_tick_third");
    step(1);
    rst_n = 1'b1;
    step(4);                       // now r+5
    bus.in_data[2] = 1'b1;
    exp_bit(7, 2, 1'b0, "pre_hold");      // r+12
    exp_bit(8, 2, 1'b1, "pre_commit");    // r+13
    step(8);                       // now r+13, glitches sit between ticks
    for (int g = 0; g < 2; g++) begin
      bus.in_data[3] = 1'b1;
      step(3);
      bus.in_data[3] = 1'b0;
      step(1);
    end
    exp_bit(4, 3, 1'b0, "pre_glitch_unseen");
    step(6);

    // reset mid-count: threshold 7, pin 4 differs for 4 ticks then reset
    bus.prescale  = 16'd0;
    bus.threshold = 4'd7;
    bus.in_data   = '0;
    step(1);
    bus.in_data[4] = 1'b1;
    step(4);
    rst_n = 1'b0;
    exp_tick(0, 1'b0, "rst_tick_low");
    push_exp(1, 2, 0, '0, "rst_mid_out");
    exp_tick(1, 1'b1, "rst_tick_back");
    exp_bit(8, 4, 1'b0, "rst_restart_hold");
    exp_bit(9, 4, 1'b1, "rst_restart_commit");
    step(1);
    rst_n = 1'b1;
    step(10);

    // threshold lowered mid-count on pin 3
    bus.threshold = 4'd10;
    bus.in_data[3] = 1'b1;
    step(5);
    bus.threshold = 4'd2;
    exp_bit(0, 3, 1'b0, "thr_before");
    exp_bit(1, 3, 1'b1, "thr_commit");
    step(1);

    // multi-pin simultaneous commit with threshold 0
    bus.threshold = 4'd0;
    bus.in_data[0]   = 1'b1;
    bus.in_data[255] = 1'b1;
    exp_bit(0, 0, 1'b0, "multi_p0_before");
    exp_bit(0, 255, 1'b0, "multi_p255_before");
    exp_bit(1, 0, 1'b1, "multi_p0_commit");
    exp_bit(1, 255, 1'b1, "multi_p255_commit");
    w = '0;
    w[0] = 1'b1; w[3] = 1'b1; w[4] = 1'b1; w[255] = 1'b1;
    push_exp(1, 2, 0, w, "multi_bus");
    step(2);

    to = 0;
    while (q.size() > 0 && to < 1000) begin
      step(1);
      to++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
